// File: rtl/usart_pkg.sv
// Shared definitions for the usart receive path: data width, default FIFO
// depth and the capture FSM state encoding.
package usart_pkg;

  localparam int DATA_W        = 8;
  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } rx_cap_state_t;

  // True when n is a power of two in the supported depth range.
  function automatic bit depth_ok(input int n);
    return (n >= 2) && (n <= 256) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/usart_rx_buffer_if.sv
// Bus between the usart receiver, the rx buffer and the host drain logic.
// OVR_CNT exists only when USART_RX_OVR_CNT_EN is defined.
interface usart_rx_buffer_if
  import usart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) ();

  localparam int AW = $clog2(DEPTH);

  // usart side
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_RDY;
  logic              RDY_CLR;

  // host side
  logic              RD_EN;
  logic [DATA_W-1:0] RD_DATA;
  logic              EMPTY;
  logic              FULL;
  logic [AW:0]       COUNT;
  logic              OVERRUN;
  logic              OVR_CLR;
`ifdef USART_RX_OVR_CNT_EN
  logic [7:0]        OVR_CNT;
`endif

  // The buffer itself.
  modport slave (
    input  RX_DATA,
    input  RX_RDY,
    output RDY_CLR,
    input  RD_EN,
    output RD_DATA,
    output EMPTY,
    output FULL,
    output COUNT,
    output OVERRUN,
    input  OVR_CLR
`ifdef USART_RX_OVR_CNT_EN
    ,
    output OVR_CNT
`endif
  );

  // Whoever drives the usart side and drains the FIFO.
  modport master (
    output RX_DATA,
    output RX_RDY,
    input  RDY_CLR,
    output RD_EN,
    input  RD_DATA,
    input  EMPTY,
    input  FULL,
    input  COUNT,
    input  OVERRUN,
    output OVR_CLR
`ifdef USART_RX_OVR_CNT_EN
    ,
    input  OVR_CNT
`endif
  );

endinterface

// File: rtl/usart_fifo_mem.sv
// DEPTH x DATA_W storage for the rx FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module usart_fifo_mem
  import usart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the incoming byte at the tail slot.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/usart_rx_buffer.sv
// Receive-side buffer behind the usart: captures each byte flagged by RX_RDY,
// acknowledges it with a one-cycle RDY_CLR pulse and queues it in a
// first-word-fall-through FIFO that the host drains with RD_EN.
// Optional dropped-byte counter OVR_CNT: define USART_RX_OVR_CNT_EN.
//
// Capture FSM
//   state    | meaning
//   IDLE     | waiting for RX_RDY; a high sample captures the byte
//   ACK      | RDY_CLR high for exactly this cycle
//   WAIT_LOW | byte consumed, waiting for the usart to drop RX_RDY
module usart_rx_buffer
  import usart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic              CLK50M,
  input logic              RST,
  usart_rx_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  rx_cap_state_t state_q, state_d;

  logic              capture;
  logic              accept;
  logic              drop;
  logic              push;
  logic              pop;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              empty_q, full_q;
  logic              rdy_clr_q;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] mem_rd_data;

  // Capture FSM next state; capture marks the cycle a byte is taken.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.RX_RDY) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.RX_RDY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A full FIFO still accepts the byte when the host pops in the same cycle.
  assign pop    = bus.RD_EN && !empty_q;
  assign accept = capture && (!full_q || bus.RD_EN);
  assign push   = accept;
  assign drop   = capture && !accept;

  // Pointer, occupancy and overrun next-state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    // A new drop beats a clear arriving in the same cycle.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.OVR_CLR) begin
      overrun_d = 1'b0;
    end
  end

  // State, pointers, count and registered flags.
  always_ff @(posedge CLK50M) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rdy_clr_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CNT_FULL);
      rdy_clr_q <= capture;
      overrun_q <= overrun_d;
    end
  end

`ifdef USART_RX_OVR_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  // Saturating dropped-byte counter; a clear with a same-cycle drop leaves 1.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (bus.OVR_CLR) begin
      ovr_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK50M) begin
    if (RST) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign bus.OVR_CNT = ovr_cnt_q;
`endif

  usart_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i     (CLK50M),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.RX_DATA),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

  assign bus.RDY_CLR = rdy_clr_q;
  assign bus.RD_DATA = empty_q ? '0 : mem_rd_data;
  assign bus.EMPTY   = empty_q;
  assign bus.FULL    = full_q;
  assign bus.COUNT   = count_q;
  assign bus.OVERRUN = overrun_q;

endmodule

// File: tb/tb_usart_rx_buffer.sv
// Randomized bench for usart_rx_buffer. A queue-based reference model updates
// on every clock edge and every output is compared one time unit later.
// OVR_CNT is checked only when USART_RX_OVR_CNT_EN is defined.
module tb_usart_rx_buffer;
  import usart_pkg::*;

  localparam int DEPTH = 16;

  logic CLK50M = 1'b0;
  logic RST;

  always #10 CLK50M = ~CLK50M;

  usart_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

  usart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .CLK50M (CLK50M),
    .RST    (RST),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] m_q[$];
  bit         m_ovr;
  int         m_ovr_cnt;
  bit         m_prev_rdy;
  bit         m_rdy_clr;
  int         clr_pct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model the edge from the rules, then compare all outputs.
  // A byte is captured when RX_RDY is seen rising (the driver always keeps it
  // high for at least two edges and low for at least one between bytes).
  task automatic tick();
    bit cap, do_pop, ok;
    @(posedge CLK50M);
    if (RST) begin
      m_q.delete();
      m_ovr      = 1'b0;
      m_ovr_cnt  = 0;
      m_prev_rdy = 1'b0;
      m_rdy_clr  = 1'b0;
    end else begin
      cap    = bus.RX_RDY && !m_prev_rdy;
      do_pop = bus.RD_EN && (m_q.size() > 0);
      ok     = cap && ((m_q.size() < DEPTH) || bus.RD_EN);
      if (do_pop) void'(m_q.pop_front());
      if (ok) m_q.push_back(bus.RX_DATA);
      if (bus.OVR_CLR) begin
        m_ovr     = 1'b0;
        m_ovr_cnt = 0;
      end
      if (cap && !ok) begin
        m_ovr = 1'b1;
        if (m_ovr_cnt < 255) m_ovr_cnt++;
      end
      m_rdy_clr  = cap;
      m_prev_rdy = bus.RX_RDY;
    end
    #1;
    chk("rdy_clr", 32'(bus.RDY_CLR), 32'(m_rdy_clr));
    chk("count",   32'(bus.COUNT),   32'(m_q.size()));
    chk("empty",   32'(bus.EMPTY),   32'(m_q.size() == 0));
    chk("full",    32'(bus.FULL),    32'(m_q.size() == DEPTH));
    chk("rd_data", 32'(bus.RD_DATA), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("overrun", 32'(bus.OVERRUN), 32'(m_ovr));
`ifdef USART_RX_OVR_CNT_EN
    chk("ovr_cnt", 32'(bus.OVR_CNT), 32'(m_ovr_cnt));
`endif
    @(negedge CLK50M);
  endtask

  task automatic rand_host(input int rd_pct);
    bus.RD_EN   = ($urandom_range(0, 99) < rd_pct);
    bus.OVR_CLR = ($urandom_range(0, 99) < clr_pct);
  endtask

  // usart-like byte delivery: present, hold `hold` extra cycles, drop, gap.
  task automatic send(input logic [7:0] b, input int rd_pct, input int hold,
                      input int gap, input bit rd_at_cap);
    bus.RX_DATA = b;
    bus.RX_RDY  = 1'b1;
    rand_host(rd_pct);
    if (rd_at_cap) bus.RD_EN = 1'b1;
    tick();
    for (int i = 0; i < hold; i++) begin
      bus.RX_DATA = 8'($urandom);
      rand_host(rd_pct);
      tick();
    end
    bus.RX_RDY = 1'b0;
    for (int i = 0; i < gap; i++) begin
      bus.RX_DATA = 8'($urandom);
      rand_host(rd_pct);
      tick();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.RX_RDY = 1'b0;
    bus.RD_EN = 1'b0;
    bus.OVR_CLR = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int pct;
    RST         = 1'b1;
    bus.RX_DATA = 8'h00;
    bus.RX_RDY  = 1'b0;
    bus.RD_EN   = 1'b0;
    bus.OVR_CLR = 1'b0;
    clr_pct     = 0;
    @(negedge CLK50M);
    do_reset();

    // first byte, then a byte held high for 5 cycles after the acknowledge
    send(8'h01, 0, 1, 1, 1'b0);
    send(8'h02, 0, 5, 2, 1'b0);
    chk("held_one_entry", 32'(bus.COUNT), 32'd2);

    // fill 01..10 with no reads
    do_reset();
    for (int i = 1; i <= DEPTH; i++) send(8'(i), 0, 1, 1, 1'b0);
    chk("fill_full",  32'(bus.FULL),  32'd1);
    chk("fill_count", 32'(bus.COUNT), 32'd16);

    // drops while full; counter saturates
    send(8'hAA, 0, 1, 1, 1'b0);
    chk("ovr_set", 32'(bus.OVERRUN), 32'd1);
    for (int i = 0; i < 300; i++) send(8'hAA, 0, 1, 1, 1'b0);
    bus.OVR_CLR = 1'b1;
    tick();
    bus.OVR_CLR = 1'b0;
    tick();
    chk("ovr_clr", 32'(bus.OVERRUN), 32'd0);

    // full with a pop in the capture cycle: new byte lands at the tail
    send(8'h5C, 0, 1, 1, 1'b1);
    chk("pushpop_count", 32'(bus.COUNT), 32'd16);

    // drain, then pop on empty
    bus.RD_EN = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) tick();
    bus.RD_EN = 1'b0;
    chk("drain_data", 32'(bus.RD_DATA), 32'd0);

    // reset while in ACK with three entries; RX_RDY still high afterwards
    do_reset();
    send(8'h11, 0, 1, 1, 1'b0);
    send(8'h22, 0, 1, 1, 1'b0);
    bus.RX_DATA = 8'h33;
    bus.RX_RDY  = 1'b1;
    tick();
    chk("pre_rst_count", 32'(bus.COUNT), 32'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_ack_rdy_clr", 32'(bus.RDY_CLR), 32'd0);
    tick();
    tick();
    bus.RX_RDY = 1'b0;
    tick();
    tick();

    // random traffic with varying drain rates and occasional clears
    clr_pct = 5;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       pct = 10;
        1:       pct = 50;
        default: pct = 90;
      endcase
      send(8'($urandom), pct, $urandom_range(1, 4), $urandom_range(1, 3),
           ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        bus.RX_RDY = 1'b0;
        for (int k = 0; k < $urandom_range(1, 6); k++) begin
          rand_host(pct);
          tick();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usart_rx_buffer.md
# usart_rx_buffer

Receive-side buffer sitting directly downstream of the `usart` block. Consumes each received byte presented on the usart's `DATA_OUT`/`Rx_RDY`, acknowledges it with a one-cycle `rdy_clr` pulse, and stores it in a DEPTH-entry first-word-fall-through FIFO. Host logic drains the FIFO at its own pace, so back-to-back received characters are never lost while the consumer is busy.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, range 2 to 256.
- `AW`, log2(DEPTH): pointer width; derived, not overridden.

Ports:
- `CLK50M`  in  1: system clock; all logic on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `RX_DATA`  in  8: byte from the usart `DATA_OUT`.
- `RX_RDY`  in  1: usart `Rx_RDY` level; high while a byte is held.
- `RDY_CLR`  out  1: to usart `rdy_clr`; one-cycle acknowledge pulse.
- `RD_EN`  in  1: pop head entry this cycle.
- `RD_DATA`  out  8: head entry (FWFT); 8'h00 when `EMPTY`.
- `EMPTY`  out  1: no entries.
- `FULL`  out  1: DEPTH entries.
- `COUNT`  out  AW+1: occupancy, 0..DEPTH.
- `OVERRUN`  out  1: sticky; a byte was dropped.
- `OVR_CLR`  in  1: clears `OVERRUN` (and `OVR_CNT` when present).
- `OVR_CNT`  out  8: dropped-byte count; present only with `USART_RX_OVR_CNT_EN`.

## Operation
- Capture FSM, states IDLE, ACK, WAIT_LOW.
  - IDLE: `RX_RDY` sampled 1 -> write `RX_DATA` into the FIFO (or drop it, see overrun), go to ACK.
  - ACK: `RDY_CLR`=1 for this cycle only; unconditionally go to WAIT_LOW.
  - WAIT_LOW: stay until `RX_RDY` is sampled 0, then go to IDLE. This keeps one usart byte from being captured twice, whatever the usart's clear latency.
- Write acceptance: the write is accepted when `FULL`=0, or when `FULL`=1 and `RD_EN`=1 in the same cycle (simultaneous pop and push, `COUNT` unchanged).
- Overrun: if the write is not accepted, the byte is discarded and `RDY_CLR` is still pulsed. `OVERRUN` is set on the next edge.
- Read: `RD_EN` with `EMPTY`=0 advances the read pointer. `RD_EN` with `EMPTY`=1 is ignored; no pointer or count change.
- Simultaneous push and pop with `EMPTY`=1: only the push takes effect.
- Pointers are AW bits and wrap modulo DEPTH. `COUNT` is held separately: +1 on push only, -1 on pop only.
- `OVR_CLR` and a new overrun in the same cycle: set wins.

## Timing
- Reset values: state IDLE, `RDY_CLR`=0, `EMPTY`=1, `FULL`=0, `COUNT`=0, `RD_DATA`=8'h00, `OVERRUN`=0, `OVR_CNT`=0. Pointers are 0. Memory contents are not reset.
- Reset mid-operation: all of the above take effect on the next edge. If `RX_RDY` is still high after `RST` falls, that byte is captured normally.
- Write latency: the edge at which IDLE samples `RX_RDY`=1 writes the entry. At that same edge `EMPTY`, `COUNT` and `RD_DATA` update and `RDY_CLR` rises. `RDY_CLR` falls one edge later.
- Capture spacing: at least 3 cycles between captures (IDLE -> ACK -> WAIT_LOW -> IDLE).
- Read: `RD_DATA` shows the new head in the cycle after the `RD_EN` edge. It is combinational from memory at the read pointer.
- All outputs are registered except `RD_DATA`.

## Configuration
- `USART_RX_OVR_CNT_EN` defined:
  - `OVR_CNT` port exists.
  - It increments once per dropped byte and saturates at 8'hFF.
  - It is cleared by `OVR_CLR` or `RST`.
- Not defined: the port and counter are absent. `OVERRUN` behaves identically in both builds.

## Structure
- Shared package `usart_pkg`:
  - `DATA_W`=8.
  - Capture state enum `rx_cap_state_t` {IDLE, ACK, WAIT_LOW}.
  - Default `DEPTH`.
- Sub-module `usart_fifo_mem`: DEPTH x 8 register array with one write port and one asynchronous read port. Pointer, count and flag logic stays in `usart_rx_buffer`.

## Test plan
- Reset, then `RX_DATA`=8'h01 with `RX_RDY` rising -> `RDY_CLR` high exactly 1 cycle; `EMPTY`=0, `COUNT`=1, `RD_DATA`=8'h01 at the capture edge.
- `RX_RDY` held high 5 cycles after `RDY_CLR` -> exactly one entry written; FSM remains in WAIT_LOW until `RX_RDY`=0.
- Loop back through `usart`, sending 8'h01..8'h10 with no reads (DEPTH=16) -> `FULL`=1, `COUNT`=16; popping 16 times returns 8'h01..8'h10 in order, then `EMPTY`=1 and `RD_DATA`=8'h00.
- FIFO full, byte 8'hAA arrives with `RD_EN`=0 -> byte dropped, `RDY_CLR` pulsed, `OVERRUN`=1, `OVR_CNT`=1 (macro build). Repeat 300 times -> `OVR_CNT`=8'hFF. `OVR_CLR` -> both 0.
- FIFO full, byte arrives with `RD_EN`=1 in the same cycle -> `COUNT` stays 16, no overrun, the new byte lands at the tail.
- `RST` asserted one cycle while in ACK with `COUNT`=3 -> next cycle `RDY_CLR`=0, `COUNT`=0, `EMPTY`=1, state IDLE.
